// File: rtl/rata_b_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rata_b_monitor
// Description : RATA-B hardware monitor. Watches PC and memory-write detectors,
//               drives the LMT update strobe and system reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rata_b_monitor #(
    parameter int                     PC_WIDTH   = 16,
    parameter int                     N_REGIONS  = 4,
    parameter int                     TS_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]    CR_MIN     = 'h0100,
    parameter logic [PC_WIDTH-1:0]    CR_AUTH    = 'h0180,
    parameter logic [PC_WIDTH-1:0]    CR_MAX     = 'h01FF,
    parameter logic [PC_WIDTH-1:0]    RESET_VEC  = 'h0000,
    parameter int                     RESET_HOLD = 4,
    parameter int                     WDT_MAX    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  mod_mem_lmt,
    input  logic [N_REGIONS-1:0]  mod_mem_ar,
    output logic                  up_lmt,
    output logic                  sys_reset,
    output logic [2:0]            current_state,
    output logic [TS_WIDTH-1:0]   lmt_value,
    output logic [N_REGIONS-1:0]  dirty_mask,
    output logic [1:0]            viol_cause
);

    localparam int WDT_W  = (WDT_MAX > 1) ? $clog2(WDT_MAX) : 1;
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [WDT_W-1:0]  C_WDT_LAST  = WDT_W'((WDT_MAX > 0) ? WDT_MAX - 1 : 0);
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam bit                C_WDT_EN    = (WDT_MAX > 0);

    localparam logic [1:0] C_CAUSE_NONE = 2'b00;
    localparam logic [1:0] C_CAUSE_LMT  = 2'b01;
    localparam logic [1:0] C_CAUSE_ATOM = 2'b10;
    localparam logic [1:0] C_CAUSE_WDT  = 2'b11;

    typedef enum logic [2:0] {
        ST_NOTMOD = 3'b000,
        ST_MOD    = 3'b001,
        ST_UPDATE = 3'b010,
        ST_ATTEST = 3'b011,
        ST_RESET  = 3'b100
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [1:0]             w_cause;
    logic                   w_in_cr;
    logic [TS_WIDTH-1:0]    r_ts;
    logic [TS_WIDTH-1:0]    r_lmt;
    logic [WDT_W-1:0]       r_wdt_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic [N_REGIONS-1:0]   r_dirty;
    logic [1:0]             r_cause;

    always_comb begin
        w_next  = r_state;
        w_cause = C_CAUSE_NONE;
        w_in_cr = (pc >= CR_MIN) && (pc <= CR_MAX);
        if (mod_mem_lmt) begin
            w_next  = ST_RESET;
            w_cause = C_CAUSE_LMT;
        end else begin
            case (r_state)
                ST_NOTMOD: if (|mod_mem_ar) w_next = ST_MOD;
                ST_MOD:    if (pc == CR_AUTH) w_next = ST_UPDATE;
                ST_UPDATE: begin
                    if (!w_in_cr) begin
                        w_next  = ST_RESET;
                        w_cause = C_CAUSE_ATOM;
                    end else if (pc != CR_AUTH) begin
                        w_next = ST_ATTEST;
                    end
                end
                // The watchdog only fires when nothing else would move the FSM
                ST_ATTEST: begin
                    if (!w_in_cr) begin
                        w_next  = ST_RESET;
                        w_cause = C_CAUSE_ATOM;
                    end else if (|mod_mem_ar) begin
                        w_next = ST_MOD;
                    end else if (pc == CR_MAX) begin
                        w_next = ST_NOTMOD;
                    end else if (C_WDT_EN && (r_wdt_cnt == C_WDT_LAST)) begin
                        w_next  = ST_RESET;
                        w_cause = C_CAUSE_WDT;
                    end
                end
                ST_RESET: begin
                    if ((r_hold_cnt == C_HOLD_LAST) && (pc == RESET_VEC)) w_next = ST_MOD;
                end
                default: w_next = ST_MOD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_MOD;
            r_ts       <= '0;
            r_lmt      <= '0;
            r_wdt_cnt  <= '0;
            r_hold_cnt <= '0;
            r_dirty    <= '0;
            r_cause    <= C_CAUSE_NONE;
        end else begin
            r_state <= w_next;
            r_ts    <= r_ts + 1'b1;

            if ((r_state == ST_MOD) && (w_next == ST_UPDATE)) r_lmt <= r_ts;

            if ((w_next == ST_ATTEST) && (r_state != ST_ATTEST)) begin
                r_wdt_cnt <= '0;
            end else if (r_state == ST_ATTEST) begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end

            // Hold counter saturates; an LMT write inside RESET restarts it
            if ((w_next == ST_RESET) && ((r_state != ST_RESET) || mod_mem_lmt)) begin
                r_hold_cnt <= '0;
            end else if ((r_state == ST_RESET) && (r_hold_cnt != C_HOLD_LAST)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end

            if (w_next == ST_RESET) begin
                r_dirty <= '0;
            end else if ((r_state == ST_ATTEST) && (w_next == ST_NOTMOD)) begin
                r_dirty <= '0;
            end else if (r_state != ST_RESET) begin
                r_dirty <= r_dirty | mod_mem_ar;
            end

            if ((r_state != ST_RESET) && (w_next == ST_RESET)) begin
                r_cause <= w_cause;
            end else if ((r_state == ST_RESET) && (w_next != ST_RESET)) begin
                r_cause <= C_CAUSE_NONE;
            end
        end
    end

    assign up_lmt        = (r_state == ST_UPDATE);
    assign sys_reset     = (r_state == ST_RESET);
    assign current_state = r_state;
    assign lmt_value     = r_lmt;
    assign dirty_mask    = r_dirty;
    assign viol_cause    = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_rata_b_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rata_b_monitor
// Description : Self-checking bench for rata_b_monitor (table, directed, random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rata_b_monitor;

    localparam int S_NOTMOD = 0, S_MOD = 1, S_UPDATE = 2, S_ATTEST = 3, S_RESET = 4;
    localparam int WDT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc;
    logic       mod_mem_lmt;
    logic [3:0] mod_mem_ar;
    logic       up_lmt, sys_reset;
    logic [2:0] current_state;
    logic [7:0] lmt_value;
    logic [3:0] dirty_mask;
    logic [1:0] viol_cause;
    logic       up_lmt0, sys_reset0;
    logic [2:0] current_state0;
    logic [7:0] lmt_value0;
    logic [3:0] dirty_mask0;
    logic [1:0] viol_cause0;

    always #5 clk = ~clk;

    rata_b_monitor #(.PC_WIDTH(8), .N_REGIONS(4), .TS_WIDTH(8), .CR_MIN(8'd10),
        .CR_AUTH(8'd12), .CR_MAX(8'd20), .RESET_VEC(8'd0), .RESET_HOLD(3), .WDT_MAX(WDT)) dut (
        .clk(clk), .rst(rst), .pc(pc), .mod_mem_lmt(mod_mem_lmt), .mod_mem_ar(mod_mem_ar),
        .up_lmt(up_lmt), .sys_reset(sys_reset), .current_state(current_state),
        .lmt_value(lmt_value), .dirty_mask(dirty_mask), .viol_cause(viol_cause));

    rata_b_monitor #(.PC_WIDTH(8), .N_REGIONS(4), .TS_WIDTH(8), .CR_MIN(8'd10),
        .CR_AUTH(8'd12), .CR_MAX(8'd20), .RESET_VEC(8'd0), .RESET_HOLD(3), .WDT_MAX(0)) dut0 (
        .clk(clk), .rst(rst), .pc(pc), .mod_mem_lmt(mod_mem_lmt), .mod_mem_ar(mod_mem_ar),
        .up_lmt(up_lmt0), .sys_reset(sys_reset0), .current_state(current_state0),
        .lmt_value(lmt_value0), .dirty_mask(dirty_mask0), .viol_cause(viol_cause0));

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: spec rules over plain integers
    int m_state, m_ts, m_lmt, m_dirty, m_cause, m_att_cycles, m_rst_cycles;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clock(input bit r, input int p, input bit l, input int a);
        int  ns, cause;
        bit  in_cr;
        if (r) begin
            m_state = S_MOD; m_ts = 0; m_lmt = 0; m_dirty = 0; m_cause = 0;
            m_att_cycles = 0; m_rst_cycles = 0;
            return;
        end
        in_cr = (p >= 10) && (p <= 20);
        ns = m_state;
        cause = 0;
        if (l) begin
            ns = S_RESET; cause = 1;
        end else if (m_state == S_NOTMOD) begin
            if (a != 0) ns = S_MOD;
        end else if (m_state == S_MOD) begin
            if (p == 12) ns = S_UPDATE;
        end else if (m_state == S_UPDATE) begin
            if (!in_cr) begin ns = S_RESET; cause = 2; end
            else if (p != 12) ns = S_ATTEST;
        end else if (m_state == S_ATTEST) begin
            if (!in_cr) begin ns = S_RESET; cause = 2; end
            else if (a != 0) ns = S_MOD;
            else if (p == 20) ns = S_NOTMOD;
            else if (m_att_cycles >= WDT - 1) begin ns = S_RESET; cause = 3; end
        end else begin
            if (m_rst_cycles >= 2 && p == 0) ns = S_MOD;
        end

        if (m_state == S_MOD && ns == S_UPDATE) m_lmt = m_ts;
        m_ts = (m_ts + 1) % 256;
        if (ns == S_RESET) m_dirty = 0;
        else if (m_state == S_ATTEST && ns == S_NOTMOD) m_dirty = 0;
        else if (m_state != S_RESET) m_dirty = m_dirty | a;
        if (m_state != S_RESET && ns == S_RESET) m_cause = cause;
        else if (m_state == S_RESET && ns != S_RESET) m_cause = 0;
        m_att_cycles = (ns == S_ATTEST && m_state == S_ATTEST) ? m_att_cycles + 1 : 0;
        m_rst_cycles = (ns == S_RESET && m_state == S_RESET && !l) ? m_rst_cycles + 1 : 0;
        m_state = ns;
    endtask

    task automatic step(input bit r, input int p, input bit l, input int a);
        rst = r; pc = 8'(p); mod_mem_lmt = l; mod_mem_ar = 4'(a);
        @(posedge clk);
        model_clock(r, p, l, a);
        #1;
        check("state", int'(current_state), m_state);
        check("up_lmt", int'(up_lmt), int'(m_state == S_UPDATE));
        check("sys_reset", int'(sys_reset), int'(m_state == S_RESET));
        check("lmt_value", int'(lmt_value), m_lmt);
        check("dirty_mask", int'(dirty_mask), m_dirty);
        check("viol_cause", int'(viol_cause), m_cause);
    endtask

    typedef struct packed {
        logic [7:0] pc;
        logic       lmt;
        logic [3:0] ar;
        logic [2:0] st;
        logic [3:0] dirty;
        logic [1:0] cause;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int  n;
        bit  done;
        int  r;
        int  p;

        tbl.push_back(vec_t'{8'd0,  1'b0, 4'h0, 3'd1, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd0,  1'b0, 4'h0, 3'd1, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd12, 1'b0, 4'h0, 3'd2, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd13, 1'b0, 4'h0, 3'd3, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd14, 1'b0, 4'h0, 3'd3, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd15, 1'b0, 4'h0, 3'd3, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd16, 1'b0, 4'h0, 3'd3, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd17, 1'b0, 4'h0, 3'd3, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd18, 1'b0, 4'h0, 3'd3, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd19, 1'b0, 4'h0, 3'd3, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd20, 1'b0, 4'h0, 3'd0, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd5,  1'b1, 4'h0, 3'd4, 4'h0, 2'd1});
        tbl.push_back(vec_t'{8'd5,  1'b0, 4'h0, 3'd4, 4'h0, 2'd1});
        tbl.push_back(vec_t'{8'd5,  1'b0, 4'h0, 3'd4, 4'h0, 2'd1});
        tbl.push_back(vec_t'{8'd5,  1'b0, 4'h0, 3'd4, 4'h0, 2'd1});
        tbl.push_back(vec_t'{8'd0,  1'b0, 4'h0, 3'd1, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd12, 1'b0, 4'h0, 3'd2, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd13, 1'b0, 4'h0, 3'd3, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd20, 1'b0, 4'h0, 3'd0, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd20, 1'b0, 4'h4, 3'd1, 4'h4, 2'd0});
        tbl.push_back(vec_t'{8'd12, 1'b0, 4'h0, 3'd2, 4'h4, 2'd0});
        tbl.push_back(vec_t'{8'd15, 1'b0, 4'h0, 3'd3, 4'h4, 2'd0});
        tbl.push_back(vec_t'{8'd30, 1'b0, 4'h0, 3'd4, 4'h0, 2'd2});
        tbl.push_back(vec_t'{8'd0,  1'b0, 4'h0, 3'd4, 4'h0, 2'd2});
        tbl.push_back(vec_t'{8'd0,  1'b0, 4'h0, 3'd4, 4'h0, 2'd2});
        tbl.push_back(vec_t'{8'd0,  1'b0, 4'h0, 3'd1, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd12, 1'b0, 4'h0, 3'd2, 4'h0, 2'd0});
        tbl.push_back(vec_t'{8'd9,  1'b0, 4'h0, 3'd4, 4'h0, 2'd2});
        tbl.push_back(vec_t'{8'd0,  1'b0, 4'hF, 3'd4, 4'h0, 2'd2});
        tbl.push_back(vec_t'{8'd0,  1'b0, 4'h0, 3'd4, 4'h0, 2'd2});
        tbl.push_back(vec_t'{8'd0,  1'b0, 4'h0, 3'd1, 4'h0, 2'd0});

        rst = 1'b1; pc = '0; mod_mem_lmt = 1'b0; mod_mem_ar = '0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_state", int'(current_state), S_MOD);
        check("rst_lmt_value", int'(lmt_value), 0);
        check("rst_outputs", int'({up_lmt, sys_reset, dirty_mask, viol_cause}), 0);

        foreach (tbl[i]) begin
            step(0, int'(tbl[i].pc), tbl[i].lmt, int'(tbl[i].ar));
            check($sformatf("tbl%0d_state", i), int'(current_state), int'(tbl[i].st));
            check($sformatf("tbl%0d_dirty", i), int'(dirty_mask), int'(tbl[i].dirty));
            check($sformatf("tbl%0d_cause", i), int'(viol_cause), int'(tbl[i].cause));
        end

        // Watchdog: WDT_MAX=8 fires on the 8th ATTEST cycle; WDT_MAX=0 never does
        step(1, 0, 0, 0);
        step(0, 12, 0, 0);
        step(0, 13, 0, 0);
        check("wdt_entry", int'(current_state), S_ATTEST);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step(0, 15, 0, 0);
            n++;
            if (current_state == 3'(S_RESET)) done = 1'b1;
            check("wdt0_state", int'(current_state0), S_ATTEST);
        end
        check("wdt_cycles", n, 8);
        check("wdt_cause", int'(viol_cause), 3);
        for (int i = 0; i < 12; i++) begin
            step(0, 15, 0, 0);
            check("wdt0_hold", int'(current_state0), S_ATTEST);
        end

        // LMT and AR writes together in ATTEST
        step(1, 0, 0, 0);
        step(0, 12, 0, 0);
        step(0, 13, 0, 0);
        step(0, 15, 1, 15);
        check("coll_state", int'(current_state), S_RESET);
        check("coll_cause", int'(viol_cause), 1);
        check("coll_dirty", int'(dirty_mask), 0);

        // Timestamp wrap: first update latches 250, second the wrapped value 2
        step(1, 0, 0, 0);
        for (int i = 0; i < 250; i++) step(0, 0, 0, 0);
        step(0, 12, 0, 0);
        check("wrap_lmt1", int'(lmt_value), 250);
        check("wrap_up1", int'(up_lmt), 1);
        step(0, 13, 0, 0);
        step(0, 14, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 12, 0, 0);
        check("wrap_lmt2", int'(lmt_value), 2);

        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      p = 0;
            else if (r < 4) p = 12;
            else if (r < 8) p = $urandom_range(10, 20);
            else if (r < 9) p = 20;
            else            p = $urandom_range(0, 255);
            step(($urandom_range(0, 199) == 0), p, ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
